alu_seq_ctrl: RTL

- Sequencing controller for the 8-bit combinational ALU (16 opcodes: add/addc/sub/subb, not/and/or/xor, shifts, rotates).
- Owns a 4-entry x 8-bit register file and the {C,Z,S,P} flag register.
- Accepts commands over a valid/ready handshake and drives the ALU operand, opcode and flag-in ports.
- Repeats an operation up to 8 passes, e.g. multi-bit shifts and rotates, and returns result and flags over a valid/ready response channel.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_seq_regfile.sv | 31 +++
 rtl/alu_seq_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU sequencing controller.
// Opcodes, flag bit positions and controller state encoding.
package alu_pkg;

  localparam int DW    = 8;
  localparam int NREG  = 4;
  localparam int RW    = 2;
  localparam int CNT_W = 3;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDC = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SUBB = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SAL  = 4'b1000;
  localparam logic [3:0] OP_SAR  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SLR  = 4'b1011;
  localparam logic [3:0] OP_RL   = 4'b1100;
  localparam logic [3:0] OP_RR   = 4'b1101;
  localparam logic [3:0] OP_RLC  = 4'b1110;
  localparam logic [3:0] OP_RRC  = 4'b1111;

  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_S = 1;
  localparam int FLG_P = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    op;
    logic [3:0]    flg;
  } aluDrv_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x DW register file: two async read ports, one sync write port.
// Contents clear asynchronously on rst_n.
module alu_seq_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [RW-1:0] wAddr,
  input  logic [DW-1:0] wData,
  input  logic [RW-1:0] rAddrA,
  input  logic [RW-1:0] rAddrB,
  output logic [DW-1:0] rDataA,
  output logic [DW-1:0] rDataB
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[wAddr] <= wData;
    end
  end

  assign rDataA = mem[rAddrA];
  assign rDataB = mem[rAddrB];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer for the 8-bit ALU: regfile, flags, multi-pass execution.
// ALU_SEQ_CTRL_PASS_CNT_EN adds a saturating EXEC-cycle counter port.
module alu_seq_ctrl
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_ld,
  input  logic [3:0]       cmd_op,
  input  logic [RW-1:0]    cmd_dst,
  input  logic [RW-1:0]    cmd_srca,
  input  logic [RW-1:0]    cmd_srcb,
  input  logic             cmd_imm_en,
  input  logic [DW-1:0]    cmd_imm,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic [3:0]       rsp_flags,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_cin,
  output logic             alu_zin,
  output logic             alu_sin,
  output logic             alu_pin,
  input  logic [DW-1:0]    alu_out,
  input  logic             alu_c,
  input  logic             alu_z,
  input  logic             alu_s,
  input  logic             alu_p
`ifdef ALU_SEQ_CTRL_PASS_CNT_EN
  ,
  output logic [15:0]      pass_cnt
`endif
);

  state_t            state, nextState;
  logic [DW-1:0]     acc, opB;
  logic [3:0]        opR;
  logic [RW-1:0]     dstR;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        flags;
  logic [3:0]        aluFlg;
  logic [DW-1:0]     rDataA, rDataB;
  logic              rfWe;
  logic [RW-1:0]     rfWAddr;
  logic [DW-1:0]     rfWData;
  logic              accept;
  logic              exec;
  aluDrv_t           live, hold, drv;

  assign aluFlg = {alu_c, alu_z, alu_s, alu_p};
  assign exec   = (state == S_EXEC);
  assign accept = (state == S_IDLE) && cmd_valid;

  alu_seq_regfile uRegs (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rfWe),
    .wAddr  (rfWAddr),
    .wData  (rfWData),
    .rAddrA (cmd_srca),
    .rAddrB (cmd_srcb),
    .rDataA (rDataA),
    .rDataB (rDataB)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    cmd_ready = 1'b0;
    rfWe      = 1'b0;
    rfWAddr   = dstR;
    rfWData   = alu_out;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        rfWAddr   = cmd_dst;
        rfWData   = cmd_imm;
        rfWe      = cmd_valid && cmd_ld;
        if (cmd_valid)
          nextState = cmd_ld ? S_DONE : S_EXEC;
      end
      S_EXEC: begin
        if (cnt == '0) begin
          rfWe      = 1'b1;
          nextState = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) nextState = S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
  end

  // ALU drive is live during EXEC and frozen at its last value otherwise.
  assign live = '{a: acc, b: opB, op: opR, flg: flags};
  assign drv  = exec ? live : hold;

  assign alu_a   = drv.a;
  assign alu_b   = drv.b;
  assign alu_op  = drv.op;
  assign alu_cin = drv.flg[FLG_C];
  assign alu_zin = drv.flg[FLG_Z];
  assign alu_sin = drv.flg[FLG_S];
  assign alu_pin = drv.flg[FLG_P];

  assign rsp_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      opB       <= '0;
      opR       <= '0;
      dstR      <= '0;
      cnt       <= '0;
      flags     <= '0;
      hold      <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
    end else begin
      if (accept) begin
        opR  <= cmd_op;
        dstR <= cmd_dst;
        acc  <= rDataA;
        opB  <= cmd_imm_en ? cmd_imm : rDataB;
        cnt  <= cmd_ld ? '0 : cmd_cnt;
        if (cmd_ld) rsp_data <= cmd_imm;
      end
      if (exec) begin
        acc   <= alu_out;
        flags <= aluFlg;
        hold  <= live;
        if (cnt == '0) begin
          rsp_data  <= alu_out;
          rsp_flags <= aluFlg;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

`ifdef ALU_SEQ_CTRL_PASS_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pass_cnt <= '0;
    else if (exec && pass_cnt != 16'hFFFF)
      pass_cnt <= pass_cnt + 1'b1;
  end
`endif

endmodule
